// File: rtl/arashi_mem_writer_if.sv
// Request/write-port bundle between the arbiter/cache side and arashi_mem_writer.
// slave = the writer (consumes rcache/toread/data_in, drives the memory write port).
interface arashi_mem_writer_if #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned MEM_WIDTH        = 10,
    parameter int unsigned THREAD_NUM_WIDTH = 2
);
    logic                        rcache;
    logic [THREAD_NUM_WIDTH-1:0] toread;
    logic [DATA_WIDTH-1:0]       data_in;
    logic                        mem_we;
    logic [MEM_WIDTH-1:0]        mem_addr;
    logic [DATA_WIDTH-1:0]       mem_wdata;

    modport master (
        output rcache, toread, data_in,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rcache, toread, data_in,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arashi_mem_writer.sv
// Write-back stage: appends drained cache words to per-thread memory regions.
// ARASHI_MEMWR_RING_EN: when defined, a full region overwrites its oldest word instead of dropping.
module arashi_mem_writer #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned MEM_WIDTH        = 10,
    parameter int unsigned THREAD_NUM_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    arashi_mem_writer_if.slave             bus,
    input  logic [(1<<THREAD_NUM_WIDTH)-1:0] clr,
    output logic [(1<<THREAD_NUM_WIDTH)*(MEM_WIDTH-THREAD_NUM_WIDTH+1)-1:0] count,
    output logic [(1<<THREAD_NUM_WIDTH)-1:0] full,
    output logic [(1<<THREAD_NUM_WIDTH)-1:0] overflow
);
    localparam int unsigned THREAD_NUM = 1 << THREAD_NUM_WIDTH;
    localparam int unsigned REGION_W   = MEM_WIDTH - THREAD_NUM_WIDTH;
    localparam int unsigned CAP_W      = REGION_W + 1;
    localparam int unsigned CAP        = 1 << REGION_W;

    // Elaboration-time parameter sanity
    if (MEM_WIDTH <= THREAD_NUM_WIDTH) begin : g_bad_region
        $error("arashi_mem_writer: REGION_W must be >= 1");
    end
    if (THREAD_NUM_WIDTH < 2 || THREAD_NUM_WIDTH > 4) begin : g_bad_threads
        $error("arashi_mem_writer: THREAD_NUM_WIDTH must be within 2..4");
    end

    typedef enum logic [1:0] {
        RG_EMPTY   = 2'd0,
        RG_PARTIAL = 2'd1,
        RG_FULL    = 2'd2
    } region_t;

    logic                        a_vld_q, a_vld_n;
    logic [THREAD_NUM_WIDTH-1:0] a_tid_q, a_tid_n;
    logic                        mem_we_q, mem_we_n;
    logic [MEM_WIDTH-1:0]        mem_addr_q, mem_addr_n;
    logic [DATA_WIDTH-1:0]       mem_wdata_q, mem_wdata_n;
    logic [REGION_W-1:0]         wptr_q [THREAD_NUM];
    logic [REGION_W-1:0]         wptr_n [THREAD_NUM];
    logic [CAP_W-1:0]            cnt_q  [THREAD_NUM];
    logic [CAP_W-1:0]            cnt_n  [THREAD_NUM];
    logic [THREAD_NUM-1:0]       ovf_q, ovf_n;
    region_t                     state_q [THREAD_NUM];
    region_t                     state_n [THREAD_NUM];

    // Register stage: request capture, write port and per-thread fill state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_vld_q     <= 1'b0;
            a_tid_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ovf_q       <= '0;
            for (int i = 0; i < int'(THREAD_NUM); i++) begin
                wptr_q[i]  <= '0;
                cnt_q[i]   <= '0;
                state_q[i] <= RG_EMPTY;
            end
        end else begin
            a_vld_q     <= a_vld_n;
            a_tid_q     <= a_tid_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            ovf_q       <= ovf_n;
            for (int i = 0; i < int'(THREAD_NUM); i++) begin
                wptr_q[i]  <= wptr_n[i];
                cnt_q[i]   <= cnt_n[i];
                state_q[i] <= state_n[i];
            end
        end
    end

    // Commit logic and per-region next-state
    always_comb begin
        a_vld_n     = bus.rcache;
        a_tid_n     = bus.toread;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        ovf_n       = ovf_q;
        for (int i = 0; i < int'(THREAD_NUM); i++) begin
            wptr_n[i]  = wptr_q[i];
            cnt_n[i]   = cnt_q[i];
            state_n[i] = state_q[i];
        end

        // A clear landing on the same edge as this thread's commit wins
        if (a_vld_q && !clr[a_tid_q]) begin
            if (state_q[a_tid_q] != RG_FULL) begin
                mem_we_n         = 1'b1;
                mem_addr_n       = {a_tid_q, wptr_q[a_tid_q]};
                mem_wdata_n      = bus.data_in;
                wptr_n[a_tid_q]  = REGION_W'(wptr_q[a_tid_q] + REGION_W'(1));
                cnt_n[a_tid_q]   = CAP_W'(cnt_q[a_tid_q] + CAP_W'(1));
            end else begin
`ifdef ARASHI_MEMWR_RING_EN
                mem_we_n         = 1'b1;
                mem_addr_n       = {a_tid_q, wptr_q[a_tid_q]};
                mem_wdata_n      = bus.data_in;
                wptr_n[a_tid_q]  = REGION_W'(wptr_q[a_tid_q] + REGION_W'(1));
`endif
                ovf_n[a_tid_q]   = 1'b1;
            end
        end

        for (int i = 0; i < int'(THREAD_NUM); i++) begin
            if (clr[i]) begin
                wptr_n[i] = '0;
                cnt_n[i]  = '0;
                ovf_n[i]  = 1'b0;
            end
            if (cnt_n[i] == '0) begin
                state_n[i] = RG_EMPTY;
            end else if (cnt_n[i] == CAP_W'(CAP)) begin
                state_n[i] = RG_FULL;
            end else begin
                state_n[i] = RG_PARTIAL;
            end
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign overflow      = ovf_q;

    for (genvar g = 0; g < int'(THREAD_NUM); g++) begin : g_thread_out
        assign count[g*CAP_W +: CAP_W] = cnt_q[g];
        assign full[g]                 = (cnt_q[g] == CAP_W'(CAP));
    end
endmodule

// File: tb/tb_arashi_mem_writer.sv
// Scoreboard bench for arashi_mem_writer: expected writes are queued at issue time and
// checked by an independent monitor whenever mem_we is seen.
module tb_arashi_mem_writer;
    localparam int unsigned DW  = 32;
    localparam int unsigned MW  = 10;
    localparam int unsigned TW  = 2;
    localparam int unsigned TN  = 1 << TW;
    localparam int unsigned CW  = MW - TW + 1;

    typedef struct packed {
        logic [MW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rstn;
    logic [TN-1:0]    clr;
    logic [TN*CW-1:0] count;
    logic [TN-1:0]    full;
    logic [TN-1:0]    overflow;

    arashi_mem_writer_if #(.DATA_WIDTH(DW), .MEM_WIDTH(MW), .THREAD_NUM_WIDTH(TW)) bus ();

    arashi_mem_writer #(.DATA_WIDTH(DW), .MEM_WIDTH(MW), .THREAD_NUM_WIDTH(TW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .clr      (clr),
        .count    (count),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    wr_t exp_q[$];
    logic [DW-1:0] pend_data = '0;

    function automatic logic [CW-1:0] cnt_of(input int t);
        return count[t*CW +: CW];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: present request, data for the previous request, and clear
    task automatic step(input logic rc, input logic [TW-1:0] tid,
                        input logic [DW-1:0] data, input logic [TN-1:0] clr_v);
        bus.rcache  = rc;
        bus.toread  = tid;
        bus.data_in = pend_data;
        clr         = clr_v;
        pend_data   = data;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [TW-1:0] tid, input logic [DW-1:0] data,
                       input bit expect_wr, input logic [MW-1:0] addr);
        if (expect_wr) exp_q.push_back('{addr: addr, data: data});
        step(1'b1, tid, data, '0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0);
    endtask

    // Monitor: every observed write must match the head of the scoreboard
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, none expected",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                    bad++;
                    $display("FAIL write: got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                             bus.mem_addr, bus.mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        rstn        = 1'b0;
        clr         = '0;
        bus.rcache  = 1'b1;
        bus.toread  = 2'd2;
        bus.data_in = 32'h1234_5678;

        // Reset with rcache held high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rstn = 1'b1;
        idle(1);
        chk("post_rst_we1", 64'(bus.mem_we), 64'd0);
        idle(1);
        chk("post_rst_we2", 64'(bus.mem_we), 64'd0);

        // Latency and addressing
        req(2'd2, 32'hA5A5_0001, 1'b1, 10'h200);
        chk("lat_we_early", 64'(bus.mem_we), 64'd0);
        idle(1);
        chk("lat_we", 64'(bus.mem_we), 64'd1);
        chk("lat_addr", 64'(bus.mem_addr), 64'h200);
        chk("lat_data", 64'(bus.mem_wdata), 64'hA5A5_0001);
        chk("lat_count2", 64'(cnt_of(2)), 64'd1);
        idle(1);
        chk("lat_we_drop", 64'(bus.mem_we), 64'd0);
        chk("lat_addr_hold", 64'(bus.mem_addr), 64'h200);

        // Streaming, alternating threads 0 and 1
        req(2'd0, 32'h0000_1000, 1'b1, 10'h000);
        req(2'd1, 32'h0000_1001, 1'b1, 10'h100);
        req(2'd0, 32'h0000_1002, 1'b1, 10'h001);
        req(2'd1, 32'h0000_1003, 1'b1, 10'h101);
        req(2'd0, 32'h0000_1004, 1'b1, 10'h002);
        req(2'd1, 32'h0000_1005, 1'b1, 10'h102);
        idle(2);
        chk("stream_count0", 64'(cnt_of(0)), 64'd3);
        chk("stream_count1", 64'(cnt_of(1)), 64'd3);
        chk("stream_count2", 64'(cnt_of(2)), 64'd1);

        // Clear collides with a thread-1 commit; the earlier thread-0 commit proceeds
        req(2'd0, 32'hC0C0_0000, 1'b1, 10'h003);
        req(2'd1, 32'hC1C1_0000, 1'b0, 10'h000);
        step(1'b0, '0, '0, 4'b0010);
        idle(2);
        chk("clr_count1", 64'(cnt_of(1)), 64'd0);
        chk("clr_ovf1", 64'(overflow[1]), 64'd0);
        chk("clr_count0", 64'(cnt_of(0)), 64'd4);
        req(2'd1, 32'hC1C1_0001, 1'b1, 10'h100);
        idle(2);
        chk("clr_next_count1", 64'(cnt_of(1)), 64'd1);

        // Fill thread 3 to capacity, then one more
        for (int i = 0; i < 256; i++) req(2'd3, 32'h3000_0000 + DW'(i), 1'b1, 10'h300 + MW'(i));
        idle(2);
        chk("full_count3", 64'(cnt_of(3)), 64'd256);
        chk("full_vec", 64'(full), 64'b1000);
        chk("full_ovf3_pre", 64'(overflow[3]), 64'd0);
`ifdef ARASHI_MEMWR_RING_EN
        req(2'd3, 32'hDEAD_0257, 1'b1, 10'h300);
`else
        req(2'd3, 32'hDEAD_0257, 1'b0, 10'h000);
`endif
        idle(1);
`ifdef ARASHI_MEMWR_RING_EN
        chk("full_257_we", 64'(bus.mem_we), 64'd1);
`else
        chk("full_257_we", 64'(bus.mem_we), 64'd0);
`endif
        idle(1);
        chk("full_ovf3", 64'(overflow[3]), 64'd1);
        chk("full_count3_after", 64'(cnt_of(3)), 64'd256);
        chk("full_vec_after", 64'(full), 64'b1000);

        // Wrap (or drop) on thread 0 after clearing it
        step(1'b0, '0, '0, 4'b0001);
        idle(1);
        chk("wrap_clr_count0", 64'(cnt_of(0)), 64'd0);
        for (int i = 0; i < 300; i++) begin
`ifdef ARASHI_MEMWR_RING_EN
            req(2'd0, 32'h0B0B_0000 + DW'(i), 1'b1, MW'(i % 256));
`else
            req(2'd0, 32'h0B0B_0000 + DW'(i), (i < 256), MW'(i));
`endif
        end
        idle(1);
`ifdef ARASHI_MEMWR_RING_EN
        chk("wrap_last_addr", 64'(bus.mem_addr), 64'h02B);
`else
        chk("wrap_last_addr", 64'(bus.mem_addr), 64'h0FF);
`endif
        idle(1);
        chk("wrap_count0", 64'(cnt_of(0)), 64'd256);
        chk("wrap_ovf0", 64'(overflow[0]), 64'd1);

        // Clearing a full, overflowed region returns it to empty
        step(1'b0, '0, '0, 4'b1000);
        idle(1);
        chk("clr3_count", 64'(cnt_of(3)), 64'd0);
        chk("clr3_full", 64'(full[3]), 64'd0);
        chk("clr3_ovf", 64'(overflow[3]), 64'd0);
        req(2'd3, 32'h3333_0000, 1'b1, 10'h300);
        idle(3);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arashi_mem_writer.md
# arashi_mem_writer

Write-back stage directly downstream of `arashi_cache`/`arashi_arbiter`. It consumes the word the cache drains whenever the arbiter asserts `rcache` for thread `toread`. It appends that word to the thread's private region of the shared data memory and drives the memory write port. It also keeps per-thread fill state: count, full and overflow.

## Interface
- `DATA_WIDTH`, 32, width of one data word
- `MEM_WIDTH`, 10, memory address width; memory depth is 2^MEM_WIDTH words
- `THREAD_NUM_WIDTH`, 2, log2 of thread count; legal range 2..4
- Derived constants:
  - THREAD_NUM = 1<<THREAD_NUM_WIDTH
  - REGION_W = MEM_WIDTH-THREAD_NUM_WIDTH
  - region capacity = 2^REGION_W words
  - elaboration `$error` unless REGION_W >= 1

- `clk`  in  1  system clock
- `rstn`  in  1  reset, synchronous, active-low
- `rcache`  in  1  arbiter read strobe to the cache
- `toread`  in  THREAD_NUM_WIDTH  thread id accompanying `rcache`
- `data_in`  in  DATA_WIDTH  cache output (`cache2mem`), valid the cycle after `rcache`
- `clr`  in  THREAD_NUM  per-thread region clear; level-sampled each cycle
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  MEM_WIDTH  write address = {thread id, region offset}
- `mem_wdata`  out  DATA_WIDTH  write data
- `count`  out  THREAD_NUM*(REGION_W+1)  words stored per thread; thread i occupies slice [i*(REGION_W+1) +: REGION_W+1]
- `full`  out  THREAD_NUM  count == capacity
- `overflow`  out  THREAD_NUM  sticky: a write was dropped because the region was full

## Operation
- Stage A (request capture): on every edge, register `rcache` → `a_vld` and `toread` → `a_tid`.
- Stage B (commit): when `a_vld`=1, sample `data_in` and act for thread t = `a_tid`:
  - **t not full:**
    - register `mem_we`=1
    - register `mem_addr`={t, wptr[t]}
    - register `mem_wdata`=`data_in`
    - wptr[t] += 1 (wraps mod 2^REGION_W)
    - count[t] += 1
  - **t full:** `mem_we`=0 and overflow[t] is set (behaviour changes under the macro).
- When `a_vld`=0: `mem_we`=0; `mem_addr`/`mem_wdata` hold their last values.
- `clr[i]`=1 at an edge sets wptr[i]=0, count[i]=0 and overflow[i]=0.
  - If a commit for thread i lands on the same edge, `clr` wins: the write is dropped, `mem_we`=0, and overflow is not set.
  - A commit for another thread on the same edge proceeds normally.
- `full` is combinational from `count`.
- Back-to-back `rcache` to the same thread every cycle is supported. Each commit sees the pointer updated by the previous commit; consecutive addresses are offsets 0,1,2,…
- No backpressure: the memory accepts one write per cycle.
- State per thread: region states EMPTY (count=0), PARTIAL, FULL.
  - EMPTY→PARTIAL on a commit.
  - PARTIAL→FULL when count reaches capacity.
  - Any state→EMPTY on `clr`.

## Timing
- `rcache`/`toread` at cycle T → `data_in` valid at T+1 → `mem_we`/`mem_addr`/`mem_wdata`/`count` updated and visible at T+2. Fixed latency of 2.
- Reset (`rstn`=0 at an edge):
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - all count=0, `full`=0, `overflow`=0
  - all wptr=0, `a_vld`=0
- Reset mid-operation discards any request in stage A. No write issues on the edge after reset deasserts.
- `rcache` asserted during reset is ignored.

## Configuration
- `ARASHI_MEMWR_RING_EN`
  - **Defined:** a full region behaves as a ring. A commit to a full thread still writes at wptr[t], advances wptr (overwriting the oldest word), keeps count at capacity, and sets overflow[t]. `mem_we`=1.
  - **Undefined:** writes to a full region are dropped: `mem_we`=0, wptr and count unchanged, overflow[t] set.

## Test plan
- **Reset:** hold `rstn`=0 for 3 cycles with `rcache`=1 → `mem_we`=0, all counts 0, no write in the first cycle after release.
- **Latency/addressing:** `rcache`=1, `toread`=2 at T; `data_in`=0xA5A5_0001 at T+1 → at T+2 `mem_we`=1, `mem_addr`=0x200, `mem_wdata`=0xA5A5_0001, count[2]=1.
- **Streaming:** `rcache` every cycle alternating threads 0,1 for 6 cycles → addresses 0x000,0x100,0x001,0x101,0x002,0x102; count[0]=count[1]=3.
- **Full (macro off):** 256 writes to thread 3 → full[3]=1, count[3]=256. 257th write → `mem_we`=0, overflow[3]=1. With the macro on, the 257th write goes to 0x300 and count stays 256.
- **Clear collision:** `clr[1]`=1 on the same edge as a thread-1 commit and a prior thread-0 commit → no thread-1 write, count[1]=0, overflow[1]=0. The next thread-1 write goes to 0x100.
- **Wrap (macro on):** 300 writes to thread 0 → last address 0x02B, count[0]=256, overflow[0]=1.
